// File: rtl/clock_group_rstseq_pkg.sv
// Shared types and constants for the clock-group reset sequencer.
// Optional feature macro: CLOCK_GROUP_RSTSEQ_STATS_EN (see top).
package clock_group_rstseq_pkg;

   localparam int CNT_W = 16;

   // Member index order matches the release order.
   localparam int SBUS_1 = 0;
   localparam int SBUS_0 = 1;
   localparam int PBUS   = 2;
   localparam int FBUS   = 3;
   localparam int MBUS   = 4;
   localparam int CBUS   = 5;

   typedef enum logic [1:0] {
      RELEASE,
      RUN,
      HOLD
   } rstseq_state_e;

endpackage

// File: rtl/rstseq_gap_counter.sv
// Loadable up-counter with terminal compare; shared by the release gap
// timing and the soft-reset hold timing.
module rstseq_gap_counter
   import clock_group_rstseq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] term_val,
   output logic             at_term
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign at_term = (cnt == term_val);

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Staged release of clock-group member resets plus soft-reset requests.
// Define CLOCK_GROUP_RSTSEQ_STATS_EN to add the soft_reset_count output.
module clock_group_reset_sequencer
   import clock_group_rstseq_pkg::*;
#(
   parameter int NUM_MEMBERS = 6,
   parameter int STAGE_GAP   = 16,
   parameter int HOLD_CYCLES = 32,
   parameter int IDX_W       = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic [NUM_MEMBERS-1:0] member_reset,
   output logic                   all_released,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [IDX_W-1:0]       req_member,
   output logic                   done,
   output logic                   done_err
`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
   ,
   output logic [CNT_W-1:0]       soft_reset_count
`endif
);

   localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [IDX_W:0]   LAST_STAGE  = (IDX_W+1)'(NUM_MEMBERS - 1);
   localparam logic [IDX_W:0]   MEMBER_LIM  = (IDX_W+1)'(NUM_MEMBERS);

   rstseq_state_e    state;
   logic [IDX_W:0]   stage;
   logic [IDX_W-1:0] held;
   logic             at_term;
   logic             cnt_load;
   logic [CNT_W-1:0] term_val;
   logic             req_fire;
   logic             req_in_range;

   // The counter idles at zero in RUN so HOLD always starts from a clean count.
   assign cnt_load     = (state == RUN) || at_term;
   assign term_val     = (state == HOLD) ? HOLD_TERM : GAP_TERM;
   assign req_fire     = req_valid && req_ready;
   assign req_in_range = ({1'b0, req_member} < MEMBER_LIM);

   rstseq_gap_counter u_gap_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val ('0),
      .term_val (term_val),
      .at_term  (at_term)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= RELEASE;
         stage        <= '0;
         held         <= '0;
         member_reset <= '1;
         all_released <= 1'b0;
         req_ready    <= 1'b0;
         done         <= 1'b0;
         done_err     <= 1'b0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         case (state)
            RELEASE: begin
               if (at_term) begin
                  member_reset[stage[IDX_W-1:0]] <= 1'b0;
                  stage <= stage + (IDX_W+1)'(1);
                  if (stage == LAST_STAGE) begin
                     state        <= RUN;
                     all_released <= 1'b1;
                     req_ready    <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (req_fire) begin
                  if (req_in_range) begin
                     member_reset[req_member] <= 1'b1;
                     held      <= req_member;
                     state     <= HOLD;
                     req_ready <= 1'b0;
                  end else begin
                     done     <= 1'b1;
                     done_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (at_term) begin
                  member_reset[held] <= 1'b0;
                  done      <= 1'b1;
                  state     <= RUN;
                  req_ready <= 1'b1;
               end
            end
            default: state <= RELEASE;
         endcase
      end
   end

`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset)
         soft_reset_count <= '0;
      else if (done && !done_err && (soft_reset_count != '1))
         soft_reset_count <= soft_reset_count + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Randomized bench for the reset sequencer, checked every cycle against an
// edge-count model of the release schedule and soft-reset windows.
module tb_clock_group_reset_sequencer;

   localparam int N  = 6;
   localparam int G  = 4;
   localparam int H  = 8;
   localparam int IW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  member_reset;
   logic          all_released;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [IW-1:0] req_member = '0;
   logic          done;
   logic          done_err;
`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
   logic [15:0]   soft_reset_count;
`endif

   always #5 clock = ~clock;

   clock_group_reset_sequencer #(
      .NUM_MEMBERS (N),
      .STAGE_GAP   (G),
      .HOLD_CYCLES (H)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .member_reset (member_reset),
      .all_released (all_released),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_member   (req_member),
      .done         (done),
      .done_err     (done_err)
`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
      ,
      .soft_reset_count (soft_reset_count)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Model: k counts edges with reset=1 since the last reset edge.
   int       k = 0;
   bit       m_known = 1'b0;
   bit [N-1:0] m_mr;
   bit       m_all, m_ready, m_done, m_err, m_hold;
   int       hold_end, held, m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at k=%0d t=%0t", name, act, exp, k, $time);
      end
   endtask

   task automatic model_edge();
      if (!reset) begin
         k = 0; m_mr = '1; m_all = 0; m_ready = 0; m_done = 0; m_err = 0;
         m_hold = 0; m_cnt = 0; m_known = 1;
      end else if (m_known) begin
         k++;
         if (m_done && !m_err && m_cnt < 65535) m_cnt++;
         m_done = 0; m_err = 0;
         if (k <= N*G) begin
            for (int i = 0; i < N; i++) m_mr[i] = (k < (i+1)*G);
            if (k == N*G) begin m_all = 1; m_ready = 1; end
         end else if (m_hold) begin
            if (k == hold_end) begin
               m_mr[held] = 0; m_done = 1; m_hold = 0; m_ready = 1;
            end
         end else if (m_ready && req_valid) begin
            if (int'(req_member) < N) begin
               held = int'(req_member); m_mr[held] = 1; hold_end = k + H;
               m_hold = 1; m_ready = 0;
            end else begin
               m_done = 1; m_err = 1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      if (m_known) begin
         check("member_reset", 32'(member_reset), 32'(m_mr));
         check("all_released", 32'(all_released), 32'(m_all));
         check("req_ready",    32'(req_ready),    32'(m_ready));
         check("done",         32'(done),         32'(m_done));
         check("done_err",     32'(done_err),     32'(m_err));
`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
         check("soft_reset_count", 32'(soft_reset_count), 32'(m_cnt));
`endif
      end
   endtask

   initial begin
      // Bring-up with req_valid held high to exercise back-pressure.
      reset = 0; req_valid = 1; req_member = 2;
      repeat (3) step();
      check("rst_member_reset", 32'(member_reset), 32'h3f);
      check("rst_ready", 32'(req_ready), 32'h0);
      reset = 1;
      for (int e = 1; e <= 44; e++) begin
         step();
         if (e == 3)  check("pin_e3",  32'(member_reset), 32'h3f);
         if (e == 4)  check("pin_e4",  32'(member_reset), 32'h3e);
         if (e == 20) check("pin_e20", 32'(member_reset), 32'h20);
         if (e == 23) check("pin_e23_all", 32'(all_released), 32'h0);
         if (e == 24) begin
            check("pin_e24_mr",  32'(member_reset), 32'h00);
            check("pin_e24_all", 32'(all_released), 32'h1);
            check("pin_e24_rdy", 32'(req_ready), 32'h1);
         end
         if (e == 25) check("pin_e25", 32'(member_reset), 32'h04);
         if (e == 32) check("pin_e32", 32'(member_reset), 32'h04);
         if (e == 33) begin
            check("pin_e33_mr",   32'(member_reset), 32'h00);
            check("pin_e33_done", 32'({done, done_err}), 32'h2);
         end
         if (e == 34) check("pin_e34_reaccept", 32'(member_reset), 32'h04);
         if (e == 36) req_valid = 0;
         if (e == 42) check("pin_e42_done", 32'(done), 32'h1);
      end
      // Out-of-range request.
      req_valid = 1; req_member = 7;
      step();
      req_valid = 0;
      check("pin_oor_done", 32'({done, done_err}), 32'h3);
      check("pin_oor_mr",   32'(member_reset), 32'h00);
      check("pin_oor_rdy",  32'(req_ready), 32'h1);
      req_valid = 1; req_member = 0;
      step();
      req_valid = 0;
      repeat (10) step();
`ifdef CLOCK_GROUP_RSTSEQ_STATS_EN
      check("pin_stats3", 32'(soft_reset_count), 32'd3);
`endif
      // Reset while holding member 4.
      req_valid = 1; req_member = 4;
      step();
      req_valid = 0;
      repeat (2) step();
      reset = 0;
      step();
      check("pin_midhold_mr",   32'(member_reset), 32'h3f);
      check("pin_midhold_done", 32'(done), 32'h0);
      reset = 1;
      repeat (30) step();
      check("pin_rerelease_all", 32'(all_released), 32'h1);
      // Randomized traffic with occasional chip resets.
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 399) != 0);
         req_valid  = ($urandom_range(0, 2) == 0);
         req_member = IW'($urandom_range(0, 7));
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
